gate_truth_checker: RTL and testbench
=====================================

Name: gate_truth_checker

Overview:
Exhaustive truth-table sequencer for the fundamental gate cells. It sits directly upstream of a gate under test and drives every input combination on vec_out. It also sits downstream of that gate: it samples the gate's y_out on y_in after a settle interval and compares the captured table against an expected table latched at start. It reports pass/fail, the observed table, the mismatch count and the first failing vector.

Parameters:
N_IN, 2, number of gate inputs driven (legal 1..4); vector count V = 2**N_IN
SETTLE_CYCLES, 2, clock cycles each vector is held before y_in is sampled (legal >= 1)

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_n_in  input  1  asynchronous active-low reset
start_in  input  1  level-sampled start request; honoured only in IDLE
abort_in  input  1  synchronous abort of a running sweep
exp_in  input  V  expected table; bit i = expected y for vector value i; latched on start
y_in  input  1  output of gate under test
vec_out  output  N_IN  stimulus vector; for 2-input gates vec_out = {a_in,b_in}
busy_out  output  1  high while a sweep runs
done_out  output  1  one-cycle pulse at sweep completion
pass_out  output  1  1 = last completed sweep had zero mismatches
obs_out  output  V  observed table; bit i = y sampled for vector i
fail_cnt_out  output  N_IN+1  mismatch count of last sweep (0..V)
first_fail_out  output  N_IN  index of first mismatching vector; 0 if none

Behaviour:
- Reset (rst_n_in low, asynchronous): all outputs 0; state IDLE; vector index idx = 0; settle counter cnt = 0; latched expectation exp_q = 0. Reset mid-sweep abandons the sweep with no done pulse.
- States: IDLE, RUN.
- IDLE, start_in = 1 at edge E0:
  - busy_out <= 1; vec_out <= 0; idx <= 0; cnt <= SETTLE_CYCLES-1; exp_q <= exp_in.
  - obs_out, fail_cnt_out, first_fail_out and pass_out all cleared to 0.
  - State moves to RUN.
- RUN, each edge:
  - abort_in = 1 has priority: go to IDLE, busy_out <= 0, vec_out <= 0, pass_out stays 0, no done pulse, partial obs_out and fail_cnt_out retained.
  - Else if cnt != 0: cnt <= cnt-1. vec_out is held.
  - Else (sample edge): obs_out[idx] <= y_in.
    - On mismatch (y_in != exp_q[idx]): fail_cnt_out increments. If this is the first mismatch of the sweep, first_fail_out <= idx.
    - If idx == V-1: go to IDLE; busy_out <= 0; done_out <= 1 for one cycle; vec_out <= 0; pass_out <= 1 iff the final fail count is 0 (include the current sample).
    - Else: idx <= idx+1; vec_out <= idx+1; cnt <= SETTLE_CYCLES-1.
- Timing:
  - Vector k is driven from edge E0+k*SETTLE_CYCLES.
  - Vector k is sampled at edge E0+(k+1)*SETTLE_CYCLES.
  - done_out is high in the cycle after edge E0+V*SETTLE_CYCLES. For defaults, done_out follows edge E0+8.
- start_in while busy_out = 1 is ignored. start_in high in the same cycle done_out is high starts a new sweep on the next edge (FSM is back in IDLE).
- abort_in in IDLE is ignored.
- exp_in changes during RUN have no effect (exp_q is used).
- Results (obs_out, fail_cnt_out, first_fail_out, pass_out) hold until the next accepted start or reset.
- fail_cnt_out never wraps; its width N_IN+1 holds V.

Optional Feature:
GATE_CHK_STOP_ON_FAIL_EN
- Defined: the first mismatching sample ends the sweep on that same edge, exactly as a completing sample does. busy_out <= 0, done_out pulses, vec_out <= 0, pass_out = 0, fail_cnt_out = 1, first_fail_out = failing idx. obs_out bits above idx remain 0.
- Undefined: all V vectors are always swept, and mismatches only accumulate.

Test Plan:
1. Defaults, gate under test = AND, exp_in = 4'b1000, start pulse: vec_out steps 0,1,2,3 every 2 cycles; done_out after edge E0+8; obs_out = 4'b1000, pass_out = 1, fail_cnt_out = 0, first_fail_out = 0.
2. Gate under test = AND, exp_in = 4'b0110 (XOR table):
   - Macro undefined: obs_out = 4'b1000, fail_cnt_out = 3, first_fail_out = 1, pass_out = 0.
   - Macro defined: done_out after edge E0+4, obs_out = 4'b0000, fail_cnt_out = 1, first_fail_out = 1.
3. Gate under test = NOR, exp_in = 4'b0001, with start_in re-pulsed at E0+3 mid-sweep and exp_in changed to 4'b1111 at E0+2: second start ignored; result uses 4'b0001; pass_out = 1; exactly one done_out pulse.
4. abort_in = 1 at E0+5 (defaults, gate = OR): busy_out = 0 after that edge; vec_out = 0; no done_out; obs_out = 4'b0010 (vectors 0 and 1 sampled); pass_out = 0.
5. rst_n_in low asynchronously at E0+3 (mid-clock): all outputs 0 immediately; after release, a new start gives a clean full sweep.
6. N_IN = 1, SETTLE_CYCLES = 1, gate = inverter, exp_in = 2'b01: vec_out 0 then 1 on consecutive cycles; done_out after edge E0+2; obs_out = 2'b01; pass_out = 1; fail_cnt_out = 0.

Source files
------------

// File: rtl/gate_truth_checker_if.sv
// Signal bundle between a truth-table sequencer (slave side) and whatever
// controls it and hosts the gate under test (master side).
interface gate_truth_checker_if #(
    parameter int N_IN = 2
);
    localparam int V = 1 << N_IN;

    logic              start_in;
    logic              abort_in;
    logic [V-1:0]      exp_in;
    logic              y_in;
    logic [N_IN-1:0]   vec_out;
    logic              busy_out;
    logic              done_out;
    logic              pass_out;
    logic [V-1:0]      obs_out;
    logic [N_IN:0]     fail_cnt_out;
    logic [N_IN-1:0]   first_fail_out;

    modport slave (
        input  start_in,
        input  abort_in,
        input  exp_in,
        input  y_in,
        output vec_out,
        output busy_out,
        output done_out,
        output pass_out,
        output obs_out,
        output fail_cnt_out,
        output first_fail_out
    );

    modport master (
        output start_in,
        output abort_in,
        output exp_in,
        output y_in,
        input  vec_out,
        input  busy_out,
        input  done_out,
        input  pass_out,
        input  obs_out,
        input  fail_cnt_out,
        input  first_fail_out
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Exhaustive truth-table sequencer for small combinational gate cells.
// Drives every input vector on vec_out, holds each one for SETTLE_CYCLES
// clocks, samples the gate output and compares it with a table latched at
// start. All outputs are registered.
//
// Optional build macro GATE_CHK_STOP_ON_FAIL_EN: when defined, the first
// mismatching sample ends the sweep on that edge; when undefined, every
// vector is swept and mismatches accumulate.
module gate_truth_checker #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    gate_truth_checker_if.slave    bus
);

    localparam int V     = 1 << N_IN;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [N_IN-1:0]  IDX_ZERO   = {N_IN{1'b0}};
    localparam logic [N_IN-1:0]  LAST_IDX   = N_IN'(V - 1);
    localparam logic [N_IN:0]    FCNT_ZERO  = {(N_IN+1){1'b0}};
    localparam logic [V-1:0]     TBL_ZERO   = {V{1'b0}};

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;

    logic [N_IN-1:0]   idx_r,        idx_s;
    logic [CNT_W-1:0]  cnt_r,        cnt_s;
    logic [V-1:0]      exp_q_r,      exp_q_s;
    logic [N_IN-1:0]   vec_r,        vec_s;
    logic              busy_r,       busy_s;
    logic              done_r,       done_s;
    logic              pass_r,       pass_s;
    logic [V-1:0]      obs_r,        obs_s;
    logic [N_IN:0]     fail_cnt_r,   fail_cnt_s;
    logic [N_IN-1:0]   first_fail_r, first_fail_s;

    // Decoded conditions of the current RUN cycle.
    logic              sample_s;
    logic              mismatch_s;
    logic              end_sweep_s;

    // Decode sample edge, mismatch and end-of-sweep for the current vector.
    always_comb begin
        sample_s    = (cnt_r == CNT_ZERO);
        mismatch_s  = (bus.y_in != exp_q_r[idx_r]);
        end_sweep_s = (idx_r == LAST_IDX) || (STOP_ON_FAIL && mismatch_s);
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort wins over sampling.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_in) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort_in) begin
                    state_s = ST_IDLE;
                end else if (sample_s && end_sweep_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        exp_q_s      = exp_q_r;
        vec_s        = vec_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        pass_s       = pass_r;
        obs_s        = obs_r;
        fail_cnt_s   = fail_cnt_r;
        first_fail_s = first_fail_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_in) begin
                    busy_s       = 1'b1;
                    vec_s        = IDX_ZERO;
                    idx_s        = IDX_ZERO;
                    cnt_s        = CNT_RELOAD;
                    exp_q_s      = bus.exp_in;
                    obs_s        = TBL_ZERO;
                    fail_cnt_s   = FCNT_ZERO;
                    first_fail_s = IDX_ZERO;
                    pass_s       = 1'b0;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.abort_in) begin
                    // Partial results stay visible; pass was cleared at start.
                    busy_s = 1'b0;
                    vec_s  = IDX_ZERO;
                    idx_s  = IDX_ZERO;
                    cnt_s  = CNT_ZERO;
                end else if (!sample_s) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    obs_s[idx_r] = bus.y_in;
                    if (mismatch_s) begin
                        // Count cannot wrap: at most V mismatches fit in N_IN+1 bits.
                        fail_cnt_s = fail_cnt_r + (N_IN+1)'(1);
                        if (fail_cnt_r == FCNT_ZERO) begin
                            first_fail_s = idx_r;
                        end else begin
                            first_fail_s = first_fail_r;
                        end
                    end else begin
                        fail_cnt_s = fail_cnt_r;
                    end
                    if (end_sweep_s) begin
                        busy_s = 1'b0;
                        done_s = 1'b1;
                        vec_s  = IDX_ZERO;
                        idx_s  = IDX_ZERO;
                        cnt_s  = CNT_ZERO;
                        pass_s = (!mismatch_s) && (fail_cnt_r == FCNT_ZERO);
                    end else begin
                        idx_s = idx_r + N_IN'(1);
                        vec_s = idx_r + N_IN'(1);
                        cnt_s = CNT_RELOAD;
                    end
                end
            end
            default: begin
                busy_s = 1'b0;
                vec_s  = IDX_ZERO;
                idx_s  = IDX_ZERO;
                cnt_s  = CNT_ZERO;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idx_r        <= IDX_ZERO;
            cnt_r        <= CNT_ZERO;
            exp_q_r      <= TBL_ZERO;
            vec_r        <= IDX_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            obs_r        <= TBL_ZERO;
            fail_cnt_r   <= FCNT_ZERO;
            first_fail_r <= IDX_ZERO;
        end else begin
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            exp_q_r      <= exp_q_s;
            vec_r        <= vec_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
            obs_r        <= obs_s;
            fail_cnt_r   <= fail_cnt_s;
            first_fail_r <= first_fail_s;
        end
    end

    assign bus.vec_out        = vec_r;
    assign bus.busy_out       = busy_r;
    assign bus.done_out       = done_r;
    assign bus.pass_out       = pass_r;
    assign bus.obs_out        = obs_r;
    assign bus.fail_cnt_out   = fail_cnt_r;
    assign bus.first_fail_out = first_fail_r;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: a 2-input instance (defaults) and a
// 1-input instance with a one-cycle settle, each driving a modelled gate.
`timescale 1ns/1ps
module tb_gate_truth_checker;

    localparam logic [1:0] G_AND = 2'd0;
    localparam logic [1:0] G_NOR = 2'd1;
    localparam logic [1:0] G_OR  = 2'd2;
    localparam logic [1:0] G_XOR = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [1:0] gate_sel;
    int         checks;
    int         failures;

    gate_truth_checker_if #(.N_IN(2)) bus2 ();
    gate_truth_checker_if #(.N_IN(1)) bus1 ();

    gate_truth_checker #(.N_IN(2), .SETTLE_CYCLES(2)) dut2 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus2.slave)
    );

    gate_truth_checker #(.N_IN(1), .SETTLE_CYCLES(1)) dut1 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test for the 2-input instance; vec_out = {a, b}.
    always_comb begin
        case (gate_sel)
            G_AND:   bus2.y_in = bus2.vec_out[1] & bus2.vec_out[0];
            G_NOR:   bus2.y_in = ~(bus2.vec_out[1] | bus2.vec_out[0]);
            G_OR:    bus2.y_in = bus2.vec_out[1] | bus2.vec_out[0];
            default: bus2.y_in = bus2.vec_out[1] ^ bus2.vec_out[0];
        endcase
    end

    // Inverter under test for the 1-input instance.
    always_comb bus1.y_in = ~bus1.vec_out[0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start across one edge (E0); returns 1 ns after E0.
    task automatic start2(input logic [3:0] e);
        bus2.exp_in   = e;
        bus2.start_in = 1'b1;
        step();
        bus2.start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({bus2.busy_out, bus2.done_out, bus2.pass_out, bus2.vec_out} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy/done/pass/vec=%b expected 00000",
                     {bus2.busy_out, bus2.done_out, bus2.pass_out, bus2.vec_out});
        end
        checks++;
        if ({bus2.obs_out, bus2.fail_cnt_out, bus2.first_fail_out} !== 9'b0) begin
            failures++;
            $display("FAIL reset_results: obs/cnt/first=%b expected 0",
                     {bus2.obs_out, bus2.fail_cnt_out, bus2.first_fail_out});
        end
        checks++;
        if ({bus1.busy_out, bus1.done_out, bus1.obs_out} !== 4'b0) begin
            failures++;
            $display("FAIL reset_n1: busy/done/obs=%b expected 0000",
                     {bus1.busy_out, bus1.done_out, bus1.obs_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_and_pass();
        logic [1:0] ev;
        gate_sel = G_AND;
        start2(4'b1000);
        checks++;
        if (bus2.busy_out !== 1'b1 || bus2.vec_out !== 2'd0) begin
            failures++;
            $display("FAIL and_start: busy=%b vec=%0d expected busy=1 vec=0",
                     bus2.busy_out, bus2.vec_out);
        end
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t < 8) begin
                ev = 2'(t / 2);
                checks++;
                if (bus2.vec_out !== ev || bus2.busy_out !== 1'b1 || bus2.done_out !== 1'b0) begin
                    failures++;
                    $display("FAIL and_step t=%0d: vec=%0d busy=%b done=%b expected vec=%0d busy=1 done=0",
                             t, bus2.vec_out, bus2.busy_out, bus2.done_out, ev);
                end
            end
        end
        checks++;
        if (bus2.done_out !== 1'b1 || bus2.busy_out !== 1'b0 || bus2.vec_out !== 2'd0) begin
            failures++;
            $display("FAIL and_done: done=%b busy=%b vec=%0d expected 1 0 0",
                     bus2.done_out, bus2.busy_out, bus2.vec_out);
        end
        checks++;
        if (bus2.obs_out !== 4'b1000 || bus2.pass_out !== 1'b1) begin
            failures++;
            $display("FAIL and_result: obs=%b pass=%b expected obs=1000 pass=1",
                     bus2.obs_out, bus2.pass_out);
        end
        checks++;
        if (bus2.fail_cnt_out !== 3'd0 || bus2.first_fail_out !== 2'd0) begin
            failures++;
            $display("FAIL and_counts: cnt=%0d first=%0d expected 0 0",
                     bus2.fail_cnt_out, bus2.first_fail_out);
        end
        step();
        checks++;
        if (bus2.done_out !== 1'b0 || bus2.pass_out !== 1'b1) begin
            failures++;
            $display("FAIL and_done_pulse: done=%b pass=%b expected done=0 pass=1",
                     bus2.done_out, bus2.pass_out);
        end
    endtask

    task automatic test_xor_expect();
        gate_sel = G_AND;
        start2(4'b0110);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        for (int t = 1; t <= 4; t++) step();
        checks++;
        if (bus2.done_out !== 1'b1 || bus2.busy_out !== 1'b0 || bus2.vec_out !== 2'd0) begin
            failures++;
            $display("FAIL xor_stop_done: done=%b busy=%b vec=%0d expected 1 0 0",
                     bus2.done_out, bus2.busy_out, bus2.vec_out);
        end
        checks++;
        if (bus2.obs_out !== 4'b0000 || bus2.fail_cnt_out !== 3'd1 ||
            bus2.first_fail_out !== 2'd1 || bus2.pass_out !== 1'b0) begin
            failures++;
            $display("FAIL xor_stop_result: obs=%b cnt=%0d first=%0d pass=%b expected 0000 1 1 0",
                     bus2.obs_out, bus2.fail_cnt_out, bus2.first_fail_out, bus2.pass_out);
        end
`else
        for (int t = 1; t <= 8; t++) step();
        checks++;
        if (bus2.done_out !== 1'b1 || bus2.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL xor_done: done=%b busy=%b expected 1 0",
                     bus2.done_out, bus2.busy_out);
        end
        checks++;
        if (bus2.obs_out !== 4'b1000 || bus2.fail_cnt_out !== 3'd3 ||
            bus2.first_fail_out !== 2'd1 || bus2.pass_out !== 1'b0) begin
            failures++;
            $display("FAIL xor_result: obs=%b cnt=%0d first=%0d pass=%b expected 1000 3 1 0",
                     bus2.obs_out, bus2.fail_cnt_out, bus2.first_fail_out, bus2.pass_out);
        end
`endif
        step();
    endtask

    task automatic test_ignore_start();
        int dones;
        dones = 0;
        gate_sel = G_NOR;
        start2(4'b0001);
        for (int t = 1; t <= 10; t++) begin
            if (t == 3) bus2.start_in = 1'b1;
            step();
            bus2.start_in = 1'b0;
            if (t == 2) bus2.exp_in = 4'b1111;
            if (t == 3) begin
                checks++;
                if (bus2.busy_out !== 1'b1 || bus2.vec_out !== 2'd1) begin
                    failures++;
                    $display("FAIL restart_ignored: busy=%b vec=%0d expected busy=1 vec=1",
                             bus2.busy_out, bus2.vec_out);
                end
            end
            if (bus2.done_out === 1'b1) dones++;
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL nor_done_count: pulses=%0d expected 1", dones);
        end
        checks++;
        if (bus2.obs_out !== 4'b0001 || bus2.pass_out !== 1'b1 || bus2.fail_cnt_out !== 3'd0) begin
            failures++;
            $display("FAIL nor_result: obs=%b pass=%b cnt=%0d expected 0001 1 0",
                     bus2.obs_out, bus2.pass_out, bus2.fail_cnt_out);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        gate_sel = G_OR;
        start2(4'b1110);
        for (int t = 1; t <= 4; t++) step();
        bus2.abort_in = 1'b1;
        step();
        bus2.abort_in = 1'b0;
        checks++;
        if (bus2.busy_out !== 1'b0 || bus2.vec_out !== 2'd0 || bus2.done_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_ctrl: busy=%b vec=%0d done=%b expected 0 0 0",
                     bus2.busy_out, bus2.vec_out, bus2.done_out);
        end
        checks++;
        if (bus2.obs_out !== 4'b0010 || bus2.pass_out !== 1'b0 || bus2.fail_cnt_out !== 3'd0) begin
            failures++;
            $display("FAIL abort_partial: obs=%b pass=%b cnt=%0d expected 0010 0 0",
                     bus2.obs_out, bus2.pass_out, bus2.fail_cnt_out);
        end
        bus2.abort_in = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            if (bus2.done_out === 1'b1) dones++;
        end
        bus2.abort_in = 1'b0;
        checks++;
        if (dones !== 0 || bus2.busy_out !== 1'b0 || bus2.obs_out !== 4'b0010) begin
            failures++;
            $display("FAIL abort_idle: dones=%0d busy=%b obs=%b expected 0 0 0010",
                     dones, bus2.busy_out, bus2.obs_out);
        end
    endtask

    task automatic test_back_to_back();
        gate_sel = G_AND;
        start2(4'b1000);
        for (int t = 1; t <= 8; t++) step();
        checks++;
        if (bus2.done_out !== 1'b1 || bus2.pass_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: done=%b pass=%b expected 1 1",
                     bus2.done_out, bus2.pass_out);
        end
        bus2.exp_in   = 4'b0110;
        bus2.start_in = 1'b1;
        step();
        bus2.start_in = 1'b0;
        checks++;
        if (bus2.busy_out !== 1'b1 || bus2.done_out !== 1'b0 || bus2.vec_out !== 2'd0 ||
            bus2.obs_out !== 4'b0000 || bus2.pass_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart: busy=%b done=%b vec=%0d obs=%b pass=%b expected 1 0 0 0000 0",
                     bus2.busy_out, bus2.done_out, bus2.vec_out, bus2.obs_out, bus2.pass_out);
        end
        for (int t = 1; t <= 8; t++) step();
        checks++;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (bus2.busy_out !== 1'b0 || bus2.fail_cnt_out !== 3'd1) begin
            failures++;
            $display("FAIL b2b_second: busy=%b cnt=%0d expected 0 1",
                     bus2.busy_out, bus2.fail_cnt_out);
        end
`else
        if (bus2.busy_out !== 1'b0 || bus2.fail_cnt_out !== 3'd3) begin
            failures++;
            $display("FAIL b2b_second: busy=%b cnt=%0d expected 0 3",
                     bus2.busy_out, bus2.fail_cnt_out);
        end
`endif
        step();
    endtask

    task automatic test_async_reset();
        gate_sel = G_AND;
        start2(4'b1000);
        for (int t = 1; t <= 3; t++) step();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus2.busy_out, bus2.done_out, bus2.pass_out, bus2.vec_out, bus2.obs_out,
             bus2.fail_cnt_out, bus2.first_fail_out} !== 14'b0) begin
            failures++;
            $display("FAIL async_reset: outputs=%b expected all 0",
                     {bus2.busy_out, bus2.done_out, bus2.pass_out, bus2.vec_out, bus2.obs_out,
                      bus2.fail_cnt_out, bus2.first_fail_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start2(4'b1000);
        for (int t = 1; t <= 8; t++) step();
        checks++;
        if (bus2.done_out !== 1'b1 || bus2.obs_out !== 4'b1000 || bus2.pass_out !== 1'b1 ||
            bus2.fail_cnt_out !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_sweep: done=%b obs=%b pass=%b cnt=%0d expected 1 1000 1 0",
                     bus2.done_out, bus2.obs_out, bus2.pass_out, bus2.fail_cnt_out);
        end
        step();
    endtask

    task automatic test_n1_inverter();
        bus1.exp_in   = 2'b01;
        bus1.start_in = 1'b1;
        step();
        bus1.start_in = 1'b0;
        checks++;
        if (bus1.busy_out !== 1'b1 || bus1.vec_out !== 1'b0) begin
            failures++;
            $display("FAIL n1_start: busy=%b vec=%b expected 1 0", bus1.busy_out, bus1.vec_out);
        end
        step();
        checks++;
        if (bus1.vec_out !== 1'b1 || bus1.done_out !== 1'b0) begin
            failures++;
            $display("FAIL n1_vec1: vec=%b done=%b expected 1 0", bus1.vec_out, bus1.done_out);
        end
        step();
        checks++;
        if (bus1.done_out !== 1'b1 || bus1.vec_out !== 1'b0 || bus1.obs_out !== 2'b01 ||
            bus1.pass_out !== 1'b1 || bus1.fail_cnt_out !== 2'd0) begin
            failures++;
            $display("FAIL n1_done: done=%b vec=%b obs=%b pass=%b cnt=%0d expected 1 0 01 1 0",
                     bus1.done_out, bus1.vec_out, bus1.obs_out, bus1.pass_out, bus1.fail_cnt_out);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        gate_sel      = G_AND;
        rst_n         = 1'b0;
        bus2.start_in = 1'b0;
        bus2.abort_in = 1'b0;
        bus2.exp_in   = 4'b0000;
        bus1.start_in = 1'b0;
        bus1.abort_in = 1'b0;
        bus1.exp_in   = 2'b00;
        test_reset();
        test_and_pass();
        test_xor_expect();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_n1_inverter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
